axis_noc_packetizer: RTL and testbench

- Injection-side stage that sits directly upstream of the mesh router's local request/response input port.
- Converts an arbitrary-length AXI-Stream burst plus sideband destination coordinates into NoC packets.
- Each packet is one header flit (target X/Y, source X/Y, flags) followed by at most MAXIMUM_PACKAGES_NUMBER-1 payload flits, with TLAST on the final flit.
- Long bursts are split into continuation packets so no packet exceeds the router arbiter's package limit.

---
 rtl/noc_pkg.sv | 47 ++++
 rtl/axis_if.sv | 15 +
 rtl/axis_noc_packetizer.sv | 155 +++++++++++++++
 tb/tb_axis_noc_packetizer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: header layout, packetizer state encoding and header builder.
package noc_pkg;

   // Field offsets for the default 4x4 mesh (2-bit coordinates).
   localparam int HDR_DEST_X_LSB = 0;
   localparam int HDR_DEST_Y_LSB = 2;
   localparam int HDR_SRC_X_LSB  = 4;
   localparam int HDR_SRC_Y_LSB  = 6;
   localparam int HDR_FIRST_BIT  = 8;
   localparam int HDR_CONT_BIT   = 9;

   // Decoded header view for the default mesh; packed so dest_x lands at bit 0.
   typedef struct packed {
      logic       cont;
      logic       first;
      logic [1:0] src_y;
      logic [1:0] src_x;
      logic [1:0] dest_y;
      logic [1:0] dest_x;
   } noc_hdr_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PAYLOAD  = 2'd1,
      ST_HDR_CONT = 2'd2
   } pkt_state_e;

   // Packs a header LSB-first for arbitrary coordinate widths; callers resize to the flit width.
   function automatic logic [63:0] build_header(input int xw, input int yw,
                                                input logic [15:0] dx, input logic [15:0] dy,
                                                input logic [15:0] sx, input logic [15:0] sy,
                                                input logic first, input logic cont);
      logic [63:0] h;
      logic [63:0] mx;
      logic [63:0] my;
      mx = (64'd1 << xw) - 64'd1;
      my = (64'd1 << yw) - 64'd1;
      h  = 64'(dx) & mx;
      h  = h | ((64'(dy) & my) << xw);
      h  = h | ((64'(sx) & mx) << (xw + yw));
      h  = h | ((64'(sy) & my) << (2 * xw + yw));
      h  = h | (64'(first) << (2 * (xw + yw)));
      h  = h | (64'(cont) << (2 * (xw + yw) + 1));
      return h;
   endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle with master and slave views.
interface axis_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) ();
   logic [DATA_WIDTH-1:0]   TDATA;
   logic                    TVALID;
   logic                    TREADY;
   logic                    TLAST;
   logic [ID_WIDTH-1:0]     TID;
   logic [DATA_WIDTH/8-1:0] TSTRB;

   modport m (output TDATA, output TVALID, output TLAST, output TID, output TSTRB, input TREADY);
   modport s (input TDATA, input TVALID, input TLAST, input TID, input TSTRB, output TREADY);
endinterface

// File: rtl/axis_noc_packetizer.sv
// Splits an AXI-Stream burst into NoC packets: one header flit followed by up to
// MAXIMUM_PACKAGES_NUMBER-1 payload flits, continuation packets for long bursts.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_IDLE     | waiting for a burst; first header issued when output is free
// ST_PAYLOAD  | forwarding input beats into the current packet
// ST_HDR_CONT | packet limit hit mid-burst; issue a continuation header
module axis_noc_packetizer
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH              = 32,
   parameter int ID_WIDTH                = 4,
   parameter int MAX_ROUTERS_X           = 4,
   parameter int MAX_ROUTERS_X_WIDTH     = $clog2(MAX_ROUTERS_X),
   parameter int MAX_ROUTERS_Y           = 4,
   parameter int MAX_ROUTERS_Y_WIDTH     = $clog2(MAX_ROUTERS_Y),
   parameter int ROUTER_X                = 0,
   parameter int ROUTER_Y                = 0,
   parameter int MAXIMUM_PACKAGES_NUMBER = 5
) (
   input  logic                           clk,
   input  logic                           rst_n,
   axis_if.s                              in,
   input  logic [MAX_ROUTERS_X_WIDTH-1:0] dest_x,
   input  logic [MAX_ROUTERS_Y_WIDTH-1:0] dest_y,
   axis_if.m                              out,
   output logic                           busy
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = (MAXIMUM_PACKAGES_NUMBER > 2) ? $clog2(MAXIMUM_PACKAGES_NUMBER) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAXIMUM_PACKAGES_NUMBER - 2);

   if (DATA_WIDTH < 2 * (MAX_ROUTERS_X_WIDTH + MAX_ROUTERS_Y_WIDTH) + 2) begin : g_chk_width
      $error("axis_noc_packetizer: DATA_WIDTH too small for header");
   end
   if (MAXIMUM_PACKAGES_NUMBER < 2) begin : g_chk_pkg
      $error("axis_noc_packetizer: MAXIMUM_PACKAGES_NUMBER must be >= 2");
   end

   pkt_state_e                     state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [MAX_ROUTERS_X_WIDTH-1:0] dest_x_q, dest_x_d;
   logic [MAX_ROUTERS_Y_WIDTH-1:0] dest_y_q, dest_y_d;
   logic [ID_WIDTH-1:0]            tid_q, tid_d;
   logic [DATA_WIDTH-1:0]          data_q, data_d;
   logic                           last_q, last_d;
   logic [ID_WIDTH-1:0]            oid_q, oid_d;
   logic [STRB_W-1:0]              strb_q, strb_d;
   logic                           valid_q, valid_d;
   logic                           out_free;
   logic                           in_ready;

   assign out_free   = !valid_q || out.TREADY;
   assign in.TREADY  = in_ready;
   assign out.TDATA  = data_q;
   assign out.TLAST  = last_q;
   assign out.TID    = oid_q;
   assign out.TSTRB  = strb_q;
   assign out.TVALID = valid_q;
   assign busy       = (state_q != ST_IDLE);

   // Next-state, output-register load and input handshake.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dest_x_d = dest_x_q;
      dest_y_d = dest_y_q;
      tid_d    = tid_q;
      data_d   = data_q;
      last_d   = last_q;
      oid_d    = oid_q;
      strb_d   = strb_q;
      valid_d  = valid_q && !out.TREADY;
      in_ready = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (in.TVALID && out_free) begin
               dest_x_d = dest_x;
               dest_y_d = dest_y;
               tid_d    = in.TID;
               data_d   = DATA_WIDTH'(build_header(MAX_ROUTERS_X_WIDTH, MAX_ROUTERS_Y_WIDTH,
                                                   16'(dest_x), 16'(dest_y),
                                                   16'(ROUTER_X), 16'(ROUTER_Y), 1'b1, 1'b0));
               last_d   = 1'b0;
               oid_d    = in.TID;
               strb_d   = '1;
               valid_d  = 1'b1;
               cnt_d    = '0;
               state_d  = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            in_ready = out_free;
            if (in.TVALID && out_free) begin
               data_d  = in.TDATA;
               last_d  = in.TLAST || (cnt_q == CNT_LAST);
               oid_d   = tid_q;
               strb_d  = in.TSTRB;
               valid_d = 1'b1;
               cnt_d   = CNT_W'(cnt_q + 1'b1);
               if (in.TLAST) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_HDR_CONT;
               end
            end
         end
         ST_HDR_CONT: begin
            if (out_free) begin
               data_d  = DATA_WIDTH'(build_header(MAX_ROUTERS_X_WIDTH, MAX_ROUTERS_Y_WIDTH,
                                                  16'(dest_x_q), 16'(dest_y_q),
                                                  16'(ROUTER_X), 16'(ROUTER_Y), 1'b0, 1'b0));
               last_d  = 1'b0;
               oid_d   = tid_q;
               strb_d  = '1;
               valid_d = 1'b1;
               state_d = ST_PAYLOAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, latched burst context and the single output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         dest_x_q <= '0;
         dest_y_q <= '0;
         tid_q    <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
         oid_q    <= '0;
         strb_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dest_x_q <= dest_x_d;
         dest_y_q <= dest_y_d;
         tid_q    <= tid_d;
         data_q   <= data_d;
         last_q   <= last_d;
         oid_q    <= oid_d;
         strb_q   <= strb_d;
         valid_q  <= valid_d;
      end
   end

endmodule

// File: tb/tb_axis_noc_packetizer.sv
// Scoreboard bench for axis_noc_packetizer (4x4 mesh, own router (0,0), 5 flits/packet).
module tb_axis_noc_packetizer;

   typedef struct packed {
      logic        hdr;
      logic [31:0] d;
      logic        l;
      logic [3:0]  id;
      logic [3:0]  s;
   } flit_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] dest_x;
   logic [1:0] dest_y;
   logic       busy;
   int         checks;
   int         errors;
   int         cyc;
   int         last_tlast_cyc;
   int         hdr_gap;
   bit         mon_en;
   bit         rand_rdy;
   logic       fix_rdy;
   flit_t      exp_q[$];

   axis_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) in_if ();
   axis_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) out_if ();

   axis_noc_packetizer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (in_if),
      .dest_x (dest_x),
      .dest_y (dest_y),
      .out    (out_if),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] strb_of(input int i);
      return 4'((i * 3 + 1) % 16);
   endfunction

   function automatic logic [31:0] hdr_word(input logic [1:0] dx, input logic [1:0] dy, input logic first);
      return (32'(first) << 8) | (32'(dy) << 2) | 32'(dx);
   endfunction

   // Expected flit stream for one burst: header every four payload beats.
   task automatic push_burst(input int n, input logic [1:0] dx, input logic [1:0] dy,
                             input logic [3:0] tid, input logic [31:0] base);
      flit_t f;
      for (int i = 0; i < n; i++) begin
         if (i % 4 == 0) begin
            f = '{hdr: 1'b1, d: hdr_word(dx, dy, i == 0), l: 1'b0, id: tid, s: 4'hF};
            exp_q.push_back(f);
         end
         f = '{hdr: 1'b0, d: base + 32'(i), l: (i == n - 1) || (i % 4 == 3), id: tid, s: strb_of(i)};
         exp_q.push_back(f);
      end
   endtask

   task automatic drive_burst(input int n, input logic [1:0] dx, input logic [1:0] dy,
                              input logic [3:0] tid, input logic [31:0] base,
                              input bit tog, input bit keep);
      int t;
      for (int i = 0; i < n; i++) begin
         in_if.TVALID = 1'b1;
         in_if.TDATA  = base + 32'(i);
         in_if.TLAST  = (i == n - 1);
         in_if.TSTRB  = strb_of(i);
         in_if.TID    = (tog && i > 0) ? ~tid : tid;
         dest_x       = (tog && i > 0) ? ~dx : dx;
         dest_y       = dy;
         t = 0;
         forever begin
            @(negedge clk);
            if (in_if.TREADY) break;
            t++;
            if (t > 200) break;
         end
         if (t > 200) begin
            chk("in_handshake_timeout", 64'(t), 64'd0);
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!keep) begin
         in_if.TVALID = 1'b0;
         in_if.TLAST  = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   // Output ready: fixed or 50% random, updated just after each rising edge.
   initial begin
      out_if.TREADY = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_if.TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
      end
   end

   // Output monitor: compare each transferred flit with the scoreboard and check stall stability.
   flit_t prev_f;
   bit    prev_stall;
   initial begin
      flit_t cur;
      flit_t e;
      prev_stall     = 1'b0;
      last_tlast_cyc = -100;
      hdr_gap        = -1;
      forever begin
         @(negedge clk);
         cur = '{hdr: 1'b0, d: out_if.TDATA, l: out_if.TLAST, id: out_if.TID, s: out_if.TSTRB};
         if (!(mon_en && rst_n)) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid", 64'(out_if.TVALID), 64'd1);
               chk("stall_stable", 64'(cur), 64'(prev_f));
            end
            if (out_if.TVALID && out_if.TREADY) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_flit", 64'(cur.d), 64'hDEAD_0000_0000);
               end else begin
                  e = exp_q.pop_front();
                  if (e.hdr) hdr_gap = cyc - last_tlast_cyc;
                  cur.hdr = e.hdr;
                  chk(e.hdr ? "hdr_flit" : "data_flit", 64'(cur), 64'(e));
               end
               if (out_if.TLAST) last_tlast_cyc = cyc;
            end
            prev_stall = out_if.TVALID && !out_if.TREADY;
            prev_f     = cur;
         end
      end
   end

   initial begin
      checks = 0; errors = 0; cyc = 0;
      mon_en = 1'b1; rand_rdy = 1'b0; fix_rdy = 1'b1;
      rst_n = 1'b0;
      in_if.TVALID = 1'b0; in_if.TDATA = '0; in_if.TLAST = 1'b0;
      in_if.TID = '0; in_if.TSTRB = '0;
      dest_x = '0; dest_y = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_tvalid", 64'(out_if.TVALID), 64'd0);
      chk("rst_tdata", 64'(out_if.TDATA), 64'd0);
      chk("rst_tready", 64'(in_if.TREADY), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;

      // Single-beat burst to (2,3).
      push_burst(1, 2'd2, 2'd3, 4'h5, 32'hA000_0000);
      drive_burst(1, 2'd2, 2'd3, 4'h5, 32'hA000_0000, 1'b0, 1'b0);
      chk("single_busy_low", 64'(busy), 64'd0);
      wait_drain();

      // 9-beat burst splits 4/4/1.
      push_burst(9, 2'd1, 2'd2, 4'h3, 32'hB000_0000);
      drive_burst(9, 2'd1, 2'd2, 4'h3, 32'hB000_0000, 1'b0, 1'b0);
      wait_drain();

      // 20-beat burst under random backpressure.
      rand_rdy = 1'b1;
      push_burst(20, 2'd3, 2'd0, 4'hA, 32'hC000_0000);
      drive_burst(20, 2'd3, 2'd0, 4'hA, 32'hC000_0000, 1'b0, 1'b0);
      wait_drain();
      rand_rdy = 1'b0;
      @(posedge clk);
      #1;

      // dest_x and TID change after first beat; headers keep the original values.
      push_burst(10, 2'd1, 2'd1, 4'h6, 32'hD000_0000);
      drive_burst(10, 2'd1, 2'd1, 4'h6, 32'hD000_0000, 1'b1, 1'b0);
      wait_drain();

      // Back-to-back bursts with TVALID held high.
      push_burst(3, 2'd2, 2'd1, 4'h1, 32'hE000_0000);
      push_burst(2, 2'd0, 2'd3, 4'h2, 32'hE100_0000);
      drive_burst(3, 2'd2, 2'd1, 4'h1, 32'hE000_0000, 1'b0, 1'b1);
      drive_burst(2, 2'd0, 2'd3, 4'h2, 32'hE100_0000, 1'b0, 1'b0);
      wait_drain();
      chk("b2b_hdr_gap", 64'(hdr_gap), 64'd1);

      // Asynchronous reset mid-payload.
      mon_en = 1'b0;
      in_if.TVALID = 1'b1; in_if.TLAST = 1'b0; in_if.TDATA = 32'h1234;
      in_if.TID = 4'h9; dest_x = 2'd3; dest_y = 2'd3;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_tvalid", 64'(out_if.TVALID), 64'd0);
      chk("arst_tready", 64'(in_if.TREADY), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      in_if.TVALID = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      push_burst(2, 2'd1, 2'd3, 4'h7, 32'hF000_0000);
      drive_burst(2, 2'd1, 2'd3, 4'h7, 32'hF000_0000, 1'b0, 1'b0);
      wait_drain();

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
